// File: rtl/nas_pkg.sv
// rtl/nas_pkg.sv - shared widths, shortcut source select and arithmetic helpers for the NAS residual stages
package nas_pkg;

    localparam int NAS_WIDTH_S = 27;
    localparam int NAS_WIDTH_M = 27;
    localparam int NAS_WIDTH_O = 27;
    localparam int NAS_DEPTH   = 1024;

    // Where the stage-1 shortcut operand comes from
    typedef enum logic [1:0] {
        SC_FIFO   = 2'd0,
        SC_BYPASS = 2'd1,
        SC_ZERO   = 2'd2
    } sc_sel_e;

    // Clamp a wide signed value into the range of a signed word of the given width
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                      input int                 width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

    // Rectified linear unit on a wide signed value
    function automatic logic signed [63:0] relu(input logic signed [63:0] value);
        if (value < 64'sd0) begin
            return 64'sd0;
        end
        return value;
    endfunction

endpackage

// File: rtl/residual_add_if.sv
// rtl/residual_add_if.sv - shortcut/main input streams and framed result stream of the residual join
interface residual_add_if
    import nas_pkg::*;
#(
    parameter int WIDTH_S = NAS_WIDTH_S,
    parameter int WIDTH_M = NAS_WIDTH_M,
    parameter int WIDTH_O = NAS_WIDTH_O
);

    // shortcut stream (arrives ahead of the main branch)
    logic               i_s_valid;
    logic [WIDTH_S-1:0] i_s_tdata;

    // main-branch conv stream with its framing
    logic               i_m_hsync;
    logic               i_m_reuse;
    logic               i_m_valid;
    logic [WIDTH_M-1:0] i_m_tdata;

    // joined result stream
    logic               o_hsync;
    logic               o_reuse;
    logic               o_valid;
    logic [WIDTH_O-1:0] o_tdata;

    modport master (
        output i_s_valid, i_s_tdata,
        output i_m_hsync, i_m_reuse, i_m_valid, i_m_tdata,
        input  o_hsync, o_reuse, o_valid, o_tdata
    );

    modport slave (
        input  i_s_valid, i_s_tdata,
        input  i_m_hsync, i_m_reuse, i_m_valid, i_m_tdata,
        output o_hsync, o_reuse, o_valid, o_tdata
    );

endinterface

// File: rtl/residual_add_sync_fifo.sv
// rtl/residual_add_sync_fifo.sv - synchronous FIFO with a 1-cycle registered read of the head word
module sync_fifo #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 27
) (
    input  logic                   i_sclk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // The caller only raises i_push for words it has decided to accept, so a
    // push while full is always paired with a pop of the same slot.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    // Simple dual-port storage; the head read returns the old word when a full
    // push overwrites the slot being popped in the same cycle
    always_ff @(posedge i_sclk) begin
        if (i_push) begin
            mem[wr_ptr] <= i_wdata;
        end
        if (i_pop) begin
            o_rdata <= mem[rd_ptr];
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks 0..DEPTH
    always_ff @(posedge i_sclk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (i_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (i_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign o_count = count;
    assign o_full  = (count == CW'(DEPTH));
    assign o_empty = (count == '0);

endmodule

// File: rtl/residual_add.sv
// rtl/residual_add.sv - residual join: buffered shortcut plus main branch, optional ReLU, saturate
module residual_add
    import nas_pkg::*;
#(
    parameter int WIDTH_S = NAS_WIDTH_S,
    parameter int WIDTH_M = NAS_WIDTH_M,
    parameter int WIDTH_O = NAS_WIDTH_O,
    parameter int DEPTH   = NAS_DEPTH,
    parameter int RELU    = 1
) (
    input  logic               i_sclk,
    input  logic               i_vsync,
    residual_add_if.slave      bus,
    output logic               o_vsync,
    output logic               o_ovf,
    output logic               o_udf
);

    localparam int WSUM = ((WIDTH_S > WIDTH_M) ? WIDTH_S : WIDTH_M) + 1;
    localparam int CW   = $clog2(DEPTH) + 1;

    // Inputs seen during a frame-sync cycle are discarded
    logic                      s_valid;
    logic                      m_valid;
    logic signed [WIDTH_S-1:0] s_tdata;
    logic signed [WIDTH_M-1:0] m_tdata;

    assign s_valid = bus.i_s_valid && !i_vsync;
    assign m_valid = bus.i_m_valid && !i_vsync;
    assign s_tdata = bus.i_s_tdata;
    assign m_tdata = bus.i_m_tdata;

    logic                      fifo_push;
    logic                      fifo_pop;
    logic signed [WIDTH_S-1:0] fifo_rdata;
    logic [CW-1:0]             fifo_count;
    logic                      fifo_full;
    logic                      fifo_empty;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH_S)
    ) u_fifo (
        .i_sclk  (i_sclk),
        .i_rst   (i_vsync),
        .i_push  (fifo_push),
        .i_wdata (s_tdata),
        .i_pop   (fifo_pop),
        .o_rdata (fifo_rdata),
        .o_count (fifo_count),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    sc_sel_e sel_now;
    logic    bypass_now;
    logic    drop_now;
    logic    udf_now;

    // Pick the shortcut source for this main word and decide push/pop/drop
    always_comb begin
        sel_now    = SC_ZERO;
        bypass_now = 1'b0;
        udf_now    = 1'b0;
        fifo_pop   = 1'b0;
        if (m_valid) begin
            if (!fifo_empty) begin
                sel_now  = SC_FIFO;
                fifo_pop = 1'b1;
            end else if (s_valid) begin
                sel_now    = SC_BYPASS;
                bypass_now = 1'b1;
            end else begin
                sel_now = SC_ZERO;
                udf_now = 1'b1;
            end
        end
        // a bypassed word is consumed directly and never enters the FIFO
        fifo_push = s_valid && !bypass_now && (!fifo_full || fifo_pop);
        drop_now  = s_valid && !bypass_now && fifo_full && !fifo_pop;
    end

    logic                      s1_valid;
    logic                      s1_hsync;
    logic                      s1_reuse;
    sc_sel_e                   s1_sel;
    logic signed [WIDTH_M-1:0] s1_main;
    logic signed [WIDTH_S-1:0] s1_bypass;

    // Stage 1: register main operand, framing and the chosen shortcut source
    always_ff @(posedge i_sclk) begin
        if (i_vsync) begin
            s1_valid  <= 1'b0;
            s1_hsync  <= 1'b0;
            s1_reuse  <= 1'b0;
            s1_sel    <= SC_ZERO;
            s1_main   <= '0;
            s1_bypass <= '0;
        end else begin
            s1_valid  <= m_valid;
            s1_hsync  <= bus.i_m_hsync;
            s1_reuse  <= bus.i_m_reuse;
            s1_sel    <= sel_now;
            s1_main   <= m_tdata;
            s1_bypass <= s_tdata;
        end
    end

    logic signed [WIDTH_S-1:0] sc_op;
    logic signed [WSUM-1:0]    sum;
    logic signed [63:0]        sum_ext;
    logic signed [63:0]        res;

    // Shortcut operand mux, full-precision add, optional ReLU, saturation
    always_comb begin
        sc_op = '0;
        case (s1_sel)
            SC_FIFO:   sc_op = fifo_rdata;
            SC_BYPASS: sc_op = s1_bypass;
            default:   sc_op = '0;
        endcase
        sum     = WSUM'(sc_op) + WSUM'(s1_main);
        sum_ext = 64'(sum);
        if (RELU != 0) begin
            sum_ext = relu(sum_ext);
        end
        res = sat_signed(sum_ext, WIDTH_O);
    end

    // Stage 2: registered result with framing; data forced to 0 when not valid
    always_ff @(posedge i_sclk) begin
        if (i_vsync) begin
            bus.o_valid <= 1'b0;
            bus.o_hsync <= 1'b0;
            bus.o_reuse <= 1'b0;
            bus.o_tdata <= '0;
        end else begin
            bus.o_valid <= s1_valid;
            bus.o_hsync <= s1_hsync;
            bus.o_reuse <= s1_reuse;
            bus.o_tdata <= s1_valid ? WIDTH_O'(res) : '0;
        end
    end

    // Sticky overflow/underflow flags held until the next frame sync
    always_ff @(posedge i_sclk) begin
        if (i_vsync) begin
            o_ovf <= 1'b0;
            o_udf <= 1'b0;
        end else begin
            if (drop_now) begin
                o_ovf <= 1'b1;
            end
            if (udf_now) begin
                o_udf <= 1'b1;
            end
        end
    end

    assign o_vsync = i_vsync;

    count_consistent: assert property (@(posedge i_sclk)
        (fifo_full == (fifo_count == CW'(DEPTH))) && (fifo_empty == (fifo_count == '0)));

endmodule

// File: tb/tb_residual_add.sv
// tb/tb_residual_add.sv - self-checking bench for residual_add (ReLU and linear variants)
module tb_residual_add;

    localparam int WS = 27;
    localparam int WM = 27;
    localparam int WO = 8;
    localparam int DP = 4;
    localparam int NS = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 vsync;
    logic                 s_valid;
    logic signed [WS-1:0] s_data;
    logic                 m_valid;
    logic signed [WM-1:0] m_data;
    logic                 m_hsync;
    logic                 m_reuse;

    residual_add_if #(.WIDTH_S(WS), .WIDTH_M(WM), .WIDTH_O(WO)) bus_r ();
    residual_add_if #(.WIDTH_S(WS), .WIDTH_M(WM), .WIDTH_O(WO)) bus_l ();

    assign bus_r.i_s_valid = s_valid;
    assign bus_r.i_s_tdata = s_data;
    assign bus_r.i_m_hsync = m_hsync;
    assign bus_r.i_m_reuse = m_reuse;
    assign bus_r.i_m_valid = m_valid;
    assign bus_r.i_m_tdata = m_data;
    assign bus_l.i_s_valid = s_valid;
    assign bus_l.i_s_tdata = s_data;
    assign bus_l.i_m_hsync = m_hsync;
    assign bus_l.i_m_reuse = m_reuse;
    assign bus_l.i_m_valid = m_valid;
    assign bus_l.i_m_tdata = m_data;

    logic vs_r, ovf_r, udf_r;
    logic vs_l, ovf_l, udf_l;

    residual_add #(.WIDTH_S(WS), .WIDTH_M(WM), .WIDTH_O(WO), .DEPTH(DP), .RELU(1)) u_relu (
        .i_sclk  (clk),
        .i_vsync (vsync),
        .bus     (bus_r),
        .o_vsync (vs_r),
        .o_ovf   (ovf_r),
        .o_udf   (udf_r)
    );

    residual_add #(.WIDTH_S(WS), .WIDTH_M(WM), .WIDTH_O(WO), .DEPTH(DP), .RELU(0)) u_lin (
        .i_sclk  (clk),
        .i_vsync (vsync),
        .bus     (bus_l),
        .o_vsync (vs_l),
        .o_ovf   (ovf_l),
        .o_udf   (udf_l)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, wanted %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected output of each clock edge: framing plus the unclamped sum
    typedef struct {
        bit valid;
        bit hsync;
        bit reuse;
        int sum;
    } exp_t;

    exp_t slots [NS];
    int   q [$];
    bit   mdl_ovf = 1'b0;
    bit   mdl_udf = 1'b0;
    int   cyc_n   = 0;

    function automatic int exp_data(input exp_t e, input bit use_relu);
        int v;
        if (!e.valid) return 0;
        v = e.sum;
        if (use_relu && v < 0) v = 0;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v;
    endfunction

    initial begin
        for (int i = 0; i < NS; i++) slots[i] = '{default: 0};
    end

    // Behavioural model: a shortcut queue of capacity DP; a result for inputs
    // sampled at edge c is visible after edge c+1
    always @(posedge clk) begin : model
        exp_t e;
        int   sc;
        if (vsync) begin
            q.delete();
            mdl_ovf = 1'b0;
            mdl_udf = 1'b0;
            slots[cyc_n % NS]       = '{default: 0};
            slots[(cyc_n + 1) % NS] = '{default: 0};
        end else begin
            e = '{valid: m_valid, hsync: m_hsync, reuse: m_reuse, sum: 0};
            if (m_valid) begin
                if (q.size() > 0) begin
                    sc = q.pop_front();
                    if (s_valid) q.push_back(int'(s_data));
                end else if (s_valid) begin
                    sc = int'(s_data);
                end else begin
                    sc = 0;
                    mdl_udf = 1'b1;
                end
                e.sum = sc + int'(m_data);
            end else if (s_valid) begin
                if (q.size() < DP) q.push_back(int'(s_data));
                else mdl_ovf = 1'b1;
            end
            slots[(cyc_n + 1) % NS] = e;
        end
        cyc_n++;
    end

    // Compare both variants against the model every cycle, away from the edge
    always @(negedge clk) begin : compare
        exp_t e;
        if (cyc_n > 0) begin
            e = slots[(cyc_n - 1) % NS];
            check("relu_valid", int'(bus_r.o_valid), int'(e.valid));
            check("relu_hsync", int'(bus_r.o_hsync), int'(e.hsync));
            check("relu_reuse", int'(bus_r.o_reuse), int'(e.reuse));
            check("relu_tdata", int'($signed(bus_r.o_tdata)), exp_data(e, 1'b1));
            check("relu_ovf", int'(ovf_r), int'(mdl_ovf));
            check("relu_udf", int'(udf_r), int'(mdl_udf));
            check("relu_vsync", int'(vs_r), int'(vsync));
            check("lin_valid", int'(bus_l.o_valid), int'(e.valid));
            check("lin_hsync", int'(bus_l.o_hsync), int'(e.hsync));
            check("lin_reuse", int'(bus_l.o_reuse), int'(e.reuse));
            check("lin_tdata", int'($signed(bus_l.o_tdata)), exp_data(e, 1'b0));
            check("lin_ovf", int'(ovf_l), int'(mdl_ovf));
            check("lin_udf", int'(udf_l), int'(mdl_udf));
        end
    end

    task automatic step(input bit vs, input bit sv, input int sd,
                        input bit mv, input int md, input bit hs, input bit ru);
        vsync   = vs;
        s_valid = sv;
        s_data  = WS'(sd);
        m_valid = mv;
        m_data  = WM'(md);
        m_hsync = hs;
        m_reuse = ru;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int sd);
        step(1'b0, 1'b1, sd, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic main(input int md, input bit hs, input bit ru);
        step(1'b0, 1'b0, 0, 1'b1, md, hs, ru);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic rst();
        step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        vsync = 1'b1; s_valid = 1'b0; s_data = '0;
        m_valid = 1'b0; m_data = '0; m_hsync = 1'b0; m_reuse = 1'b0;
        rst(); rst(); rst();
        check("pin_reset_valid", int'(bus_r.o_valid), 0);
        check("pin_reset_tdata", int'(bus_r.o_tdata), 0);
        check("pin_reset_vsync", int'(vs_r), 1);

        // basic add: 5+10, -3+10, 100-200
        idle();
        check("pin_vsync_low", int'(vs_r), 0);
        push(5); push(-3); push(100); idle();
        main(10, 1'b1, 1'b0);
        main(10, 1'b0, 1'b1);
        check("pin_basic0", int'($signed(bus_r.o_tdata)), 15);
        check("pin_basic0_hsync", int'(bus_r.o_hsync), 1);
        main(-200, 1'b0, 1'b0);
        check("pin_basic1", int'($signed(bus_r.o_tdata)), 7);
        check("pin_basic1_reuse", int'(bus_r.o_reuse), 1);
        idle();
        check("pin_basic2_relu", int'($signed(bus_r.o_tdata)), 0);
        check("pin_basic2_lin", int'($signed(bus_l.o_tdata)), -100);
        check("pin_basic2_valid", int'(bus_r.o_valid), 1);
        idle();
        check("pin_basic_done_valid", int'(bus_r.o_valid), 0);

        // bypass with an empty FIFO
        step(1'b0, 1'b1, 4, 1'b1, 6, 1'b0, 1'b0);
        check("pin_bypass_udf", int'(udf_r), 0);
        idle();
        check("pin_bypass", int'($signed(bus_r.o_tdata)), 10);

        // underflow: nothing queued after the bypass
        main(1, 1'b0, 1'b0);
        check("pin_udf_set", int'(udf_r), 1);
        main(-5, 1'b0, 1'b0);
        check("pin_udf_data", int'($signed(bus_r.o_tdata)), 1);
        idle();
        check("pin_udf_relu", int'($signed(bus_r.o_tdata)), 0);
        check("pin_udf_lin", int'($signed(bus_l.o_tdata)), -5);
        idle();
        check("pin_udf_held", int'(udf_r), 1);
        rst();
        check("pin_udf_cleared", int'(udf_r), 0);

        // saturation to 8 bits
        idle();
        push(100); main(100, 1'b0, 1'b0); idle();
        check("pin_sat_pos", int'($signed(bus_r.o_tdata)), 127);
        push(-100); main(-100, 1'b0, 1'b0); idle();
        check("pin_sat_neg_lin", int'($signed(bus_l.o_tdata)), -128);
        check("pin_sat_neg_relu", int'($signed(bus_r.o_tdata)), 0);

        // overflow: 5th push dropped
        rst(); idle();
        push(1); push(2); push(3); push(4);
        check("pin_ovf_before", int'(ovf_r), 0);
        push(5);
        check("pin_ovf_set", int'(ovf_r), 1);
        main(10, 1'b1, 1'b0); main(10, 1'b0, 1'b0);
        check("pin_ovf_first", int'($signed(bus_r.o_tdata)), 11);
        main(10, 1'b0, 1'b1); main(10, 1'b0, 1'b0);
        main(10, 1'b0, 1'b0);
        check("pin_ovf_last", int'($signed(bus_r.o_tdata)), 14);
        idle();
        check("pin_ovf_lost", int'($signed(bus_r.o_tdata)), 10);
        check("pin_ovf_udf", int'(udf_r), 1);

        // full FIFO with simultaneous push and pop
        rst(); idle();
        push(1); push(2); push(3); push(4);
        step(1'b0, 1'b1, 9, 1'b1, 20, 1'b1, 1'b0);
        check("pin_full_pp_ovf", int'(ovf_r), 0);
        main(20, 1'b0, 1'b0);
        check("pin_full_pp_data", int'($signed(bus_r.o_tdata)), 21);
        main(20, 1'b0, 1'b0); main(20, 1'b0, 1'b0); main(20, 1'b0, 1'b0);
        idle();
        check("pin_full_pp_last", int'($signed(bus_r.o_tdata)), 29);
        check("pin_full_pp_udf", int'(udf_r), 0);

        // mid-row reset with words queued and output active
        rst(); idle();
        push(1); push(2); push(3); push(4);
        main(10, 1'b1, 1'b1);
        step(1'b0, 1'b1, 6, 1'b1, 10, 1'b0, 1'b0);
        check("pin_mid_active", int'(bus_r.o_valid), 1);
        step(1'b1, 1'b1, 8, 1'b1, 10, 1'b1, 1'b1);
        check("pin_mid_valid", int'(bus_r.o_valid), 0);
        check("pin_mid_tdata", int'(bus_r.o_tdata), 0);
        check("pin_mid_hsync", int'(bus_r.o_hsync), 0);
        step(1'b0, 1'b1, 7, 1'b1, 3, 1'b0, 1'b0);
        check("pin_mid_flush", int'(bus_r.o_valid), 0);
        main(2, 1'b0, 1'b0);
        check("pin_mid_bypass", int'($signed(bus_r.o_tdata)), 10);
        check("pin_mid_udf", int'(udf_r), 1);
        idle(); idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
